// File: rtl/step_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : step_pattern_sequencer
// Description : Step pattern memory and sequencer. It drives the tone Select
//               bus of audio_interface one step per bpm_step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pattern_sequencer #(
    parameter int STEPS = 16,
    parameter int AW    = 4,
    parameter int TONES = 12
) (
    input  logic             CLOCK_50,
    input  logic             nReset,
    input  logic             nStart,
    input  logic             bpm_step,
    input  logic             play_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [TONES-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [TONES-1:0] rd_data,
    output logic [TONES-1:0] Select,
    output logic [AW-1:0]    step_idx,
    output logic [STEPS-1:0] step_led,
    output logic             running
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_armed = 2'd1;
    localparam logic [1:0]    c_st_run   = 2'd2;
    localparam logic [AW-1:0] c_last     = AW'(STEPS - 1);

    logic [1:0]       state_q, state_d;
    logic             nstart_q;
    logic [AW-1:0]    step_idx_q, step_idx_d;
    logic [TONES-1:0] select_q, select_d;
    logic [TONES-1:0] rd_data_q, rd_data_d;
    logic [TONES-1:0] mem_q [STEPS];
    logic [TONES-1:0] mem_d [STEPS];

    logic             w_start;
    logic             w_load;
    logic             w_clear;
    logic [AW-1:0]    w_load_addr;
    logic [TONES-1:0] w_load_val;

    assign w_start = nstart_q & ~nStart;

    // State register and all datapath flops
    always_ff @(posedge CLOCK_50) begin
        if (!nReset) begin
            state_q    <= c_st_idle;
            nstart_q   <= 1'b1;
            step_idx_q <= '0;
            select_q   <= '0;
            rd_data_q  <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            nstart_q   <= nStart;
            step_idx_q <= step_idx_d;
            select_q   <= select_d;
            rd_data_q  <= rd_data_d;
            mem_q      <= mem_d;
        end
    end

    // Next-state logic; a start request overrides every other condition
    always_comb begin
        state_d     = state_q;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_load_addr = '0;
        if (w_start) begin
            state_d = c_st_armed;
            w_load  = 1'b1;
        end else begin
            case (state_q)
                c_st_idle: begin
                    state_d = c_st_idle;
                end
                c_st_armed: begin
                    if (play_en) state_d = c_st_run;
                end
                c_st_run: begin
                    if (!play_en) begin
                        state_d = c_st_idle;
                        w_clear = 1'b1;
                    end else if (bpm_step) begin
                        w_load      = 1'b1;
                        w_load_addr = (step_idx_q == c_last) ? '0 : step_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = c_st_idle;
                    w_clear = 1'b1;
                end
            endcase
        end
    end

    // Memory write, read port and step load (write-through on a same-cycle write)
    always_comb begin
        mem_d      = mem_q;
        rd_data_d  = '0;
        w_load_val = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (wr_en && (wr_addr == AW'(i))) mem_d[i] = wr_data;
            if (rd_addr == AW'(i)) rd_data_d = mem_q[i];
            if (w_load_addr == AW'(i))
                w_load_val = (wr_en && (wr_addr == w_load_addr)) ? wr_data : mem_q[i];
        end
        step_idx_d = step_idx_q;
        select_d   = select_q;
        if (w_clear) begin
            step_idx_d = '0;
            select_d   = '0;
        end else if (w_load) begin
            step_idx_d = w_load_addr;
            select_d   = w_load_val;
        end
    end

    // Output logic
    always_comb begin
        running  = (state_q == c_st_run);
        Select   = select_q;
        step_idx = step_idx_q;
        rd_data  = rd_data_q;
        step_led = '0;
        for (int i = 0; i < STEPS; i++) begin
            step_led[i] = (state_q != c_st_idle) && (step_idx_q == AW'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_pattern_sequencer
// Description : Directed self-checking bench; a 4-step and an 8-step instance
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pattern_sequencer;

    logic        clk = 1'b0;
    logic        nReset, nStart, bpm_step, play_en, wr_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [11:0] wr_data;

    logic [11:0] rd_data4, select4, rd_data8, select8;
    logic [3:0]  idx4, idx8;
    logic [3:0]  led4;
    logic [7:0]  led8;
    logic        running4, running8;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    step_pattern_sequencer #(.STEPS(4), .AW(4), .TONES(12)) u_dut4 (
        .CLOCK_50(clk), .nReset(nReset), .nStart(nStart), .bpm_step(bpm_step),
        .play_en(play_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data4), .Select(select4),
        .step_idx(idx4), .step_led(led4), .running(running4)
    );

    step_pattern_sequencer #(.STEPS(8), .AW(4), .TONES(12)) u_dut8 (
        .CLOCK_50(clk), .nReset(nReset), .nStart(nStart), .bpm_step(bpm_step),
        .play_en(play_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data8), .Select(select8),
        .step_idx(idx8), .step_led(led8), .running(running8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse();
        bpm_step = 1'b1;
        tick();
        bpm_step = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_sel [5];
        logic [3:0]  exp_led [5];
        exp_sel = '{12'h002, 12'h004, 12'h008, 12'h001, 12'h002};
        exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        nReset = 1'b0; nStart = 1'b1; bpm_step = 1'b0; play_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        nReset = 1'b1;
        chk("reset_select", select4, 0);
        chk("reset_running", running4, 0);
        chk("reset_led", led4, 0);

        // Reset clears pattern memory
        write(4'd3, 12'h00F);
        rd_addr = 4'd3;
        tick();
        chk("pre_reset_rd3", rd_data4, 12'h00F);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        tick();
        chk("post_reset_rd3", rd_data4, 0);
        chk("post_reset_select", select4, 0);
        chk("post_reset_running", running4, 0);

        // Basic run with wrap
        write(4'd0, 12'h001);
        write(4'd1, 12'h002);
        write(4'd2, 12'h004);
        write(4'd3, 12'h008);
        nStart = 1'b0;
        tick();
        nStart = 1'b1;
        chk("armed_select", select4, 12'h001);
        chk("armed_led", led4, 4'b0001);
        chk("armed_running", running4, 0);
        play_en = 1'b1;
        tick();
        chk("run_running", running4, 1);
        chk("run_select0", select4, 12'h001);
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk($sformatf("run_select_%0d", i), select4, exp_sel[i]);
            chk($sformatf("run_led_%0d", i), led4, exp_led[i]);
            tick();
        end

        // Stop coinciding with a step pulse: no step-2 -> step-3 load
        pulse();
        chk("pre_stop_select", select4, 12'h004);
        bpm_step = 1'b1; play_en = 1'b0;
        tick();
        bpm_step = 1'b0;
        chk("stop_select", select4, 0);
        chk("stop_idx", idx4, 0);
        chk("stop_led", led4, 0);
        chk("stop_running", running4, 0);

        // ARMED ignores step pulses
        nStart = 1'b0;
        tick();
        nStart = 1'b1;
        pulse(); pulse(); pulse();
        chk("hold_select", select4, 12'h001);
        chk("hold_idx", idx4, 0);
        chk("hold_running", running4, 0);
        play_en = 1'b1;
        tick();
        chk("hold_to_run", running4, 1);

        // Write-through on the loading step, then write to the playing step
        bpm_step = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 12'hABC;
        tick();
        bpm_step = 1'b0; wr_en = 1'b0;
        chk("wt_select", select4, 12'hABC);
        chk("wt_idx", idx4, 1);
        write(4'd1, 12'h123);
        chk("playing_write_select", select4, 12'hABC);

        // Restart from step 3, holding nStart low must not retrigger
        pulse();
        pulse();
        chk("pre_restart_idx", idx4, 3);
        nStart = 1'b0;
        tick();
        chk("restart_select", select4, 12'h001);
        chk("restart_idx", idx4, 0);
        chk("restart_running", running4, 0);
        chk("restart_led", led4, 4'b0001);
        tick();
        chk("no_retrigger_running", running4, 1);
        pulse();
        chk("no_retrigger_idx", idx4, 1);
        chk("no_retrigger_select", select4, 12'h123);
        nStart = 1'b1;

        // Out-of-range writes are dropped
        write(4'd7, 12'h055);
        write(4'd15, 12'hFFF);
        rd_addr = 4'd7;
        tick();
        chk("oor_rd7_steps8", rd_data8, 12'h055);
        chk("oor_rd7_steps4", rd_data4, 0);
        rd_addr = 4'd15;
        tick();
        chk("oor_rd15_steps8", rd_data8, 0);
        rd_addr = 4'd1;
        tick();
        chk("rd1_steps4", rd_data4, 12'h123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_pattern_sequencer.md
# step_pattern_sequencer

Pattern memory and step sequencer that feeds the 12-bit tone `Select` bus of `audio_interface`. It stores one 12-bit tone mask per step, is started by the same `nStart` request, and advances one step on every `bpm_step` pulse while `play_en` is high. It returns to idle when `play_en` drops at the end of the programmed loops. Pattern contents are written from the user-input logic through a simple synchronous write port, and a read port serves the display logic.

## Interface
Parameters:
- STEPS, 16, number of steps in the pattern (2..16)
- AW, 4, step address width; must satisfy 2^AW >= STEPS
- TONES, 12, tone mask width; must equal the width of the `Select` bus

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge
- nReset  in  1  reset; synchronous, active-low
- nStart  in  1  active-low start request (level); only its falling edge acts
- bpm_step  in  1  one-cycle step pulse from `audio_interface`
- play_en  in  1  playback-active level from `audio_interface`
- wr_en  in  1  pattern write strobe
- wr_addr  in  AW  step address to write
- wr_data  in  TONES  tone mask to write
- rd_addr  in  AW  display read address
- rd_data  out  TONES  registered contents of mem[rd_addr]
- Select  out  TONES  tone mask for the current step; drives `audio_interface.Select`
- step_idx  out  AW  current step number
- step_led  out  STEPS  one-hot current-step indicator
- running  out  1  high while in RUN

## Operation
- Storage: mem[0..STEPS-1], each entry TONES bits wide. Reset clears every entry to 0.
- Writes: when wr_en=1 and wr_addr<STEPS, mem[wr_addr] <= wr_data. Writes with wr_addr>=STEPS are ignored. Writes are accepted in every state.
- Reads: rd_data <= mem[rd_addr] every cycle. An out-of-range rd_addr returns 0.
- Start detect: nStart_q holds the previous sample of nStart. start = nStart_q & ~nStart. nStart_q resets to 1.
- States:
  - IDLE: Select=0, step_idx=0, step_led=0, running=0. On start: go to ARMED, step_idx<=0, Select<=mem[0].
  - ARMED: outputs hold step 0; step_led=1<<0. When play_en=1: go to RUN. bpm_step is ignored in ARMED.
  - RUN: running=1. On bpm_step & play_en: step_idx<=(step_idx==STEPS-1)?0:step_idx+1 and Select<=mem[next]. When play_en=0: go to IDLE and clear Select/step_idx/step_led in the same edge.
- Restart: a start in ARMED or RUN returns the block to ARMED at step 0 and reloads Select<=mem[0]. Start takes priority over bpm_step and over play_en=0.
- Write-through: if a load of step n coincides with a write to address n, Select takes wr_data.
- A write to the step currently playing does not change Select until that step is loaded again.
- step_led = one-hot of step_idx in ARMED and RUN; 0 in IDLE.

## Timing
- Reset (nReset=0 at a rising edge): next-edge outputs are Select=0, step_idx=0, step_led=0, running=0, rd_data=0; state=IDLE; all mem entries 0. This applies from any state, including mid-RUN.
- Start latency: nStart is sampled low at edge k (after high at k-1). Select=mem[0] and state ARMED are visible after edge k.
- Step latency: bpm_step is high in the cycle before edge k. Select and step_idx are updated after edge k (one cycle).
- Stop latency: play_en is sampled low at edge k in RUN. IDLE outputs are visible after edge k.
- rd_data latency: one cycle. Writes are visible to rd_data one cycle after the write edge.
- Wrap: step STEPS-1 plus bpm_step gives step 0, with no gap cycle.
- bpm_step and play_en falling in the same cycle: stop wins and no step is loaded.

## Test plan
- Reset: write mem[3]=12'h00F, then pulse nReset low for 1 cycle. Required: rd_data of addr 3 reads 0, Select=0, running=0.
- Basic run: load mem[0..3]=001,002,004,008 with STEPS=4; pulse nStart; raise play_en; give 5 bpm_step pulses. Required: Select sequence 001,002,004,008,001,002; step_led 0001,0010,0100,1000,0001,0010.
- ARMED hold: start with play_en=0 and apply 3 bpm_step pulses. Required: Select stays mem[0], step_idx=0, running=0. Then raise play_en. Required: running=1 after one edge.
- Stop: drop play_en at step 2, in the same cycle as a bpm_step. Required: next edge Select=0, step_idx=0, step_led=0, no step-3 load.
- Write-through: write mem[1]=12'hABC in the same cycle as the bpm_step that loads step 1. Required: Select=ABC. A write to mem[1] while step 1 is playing leaves Select unchanged.
- Restart/edge cases: nStart falling edge at step 3 in RUN. Required: ARMED with Select=mem[0]. Holding nStart low does not retrigger. A write with wr_addr=15 when STEPS=8 leaves mem unchanged.
